demux_lane_collector: RTL and testbench



---
 rtl/demux_collect_pkg.sv | 16 +
 rtl/demux_lane_asm.sv | 62 ++++++
 rtl/demux_lane_collector.sv | 73 +++++++
 tb/tb_demux_lane_collector.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/demux_collect_pkg.sv
// demux_collect_pkg: shared lane constants, arbiter state enum and round-robin pick helper.
// Optional parity support elsewhere is enabled with DEMUX_COLLECT_PARITY_EN.
package demux_collect_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W = 2;
  typedef enum logic {ARB_IDLE, ARB_PRESENT} arb_state_e;
  function automatic logic [LANE_W-1:0] rr_pick(input logic [NUM_LANES-1:0] req, input logic [LANE_W-1:0] ptr);
    logic [LANE_W-1:0] idx;
    rr_pick = ptr;
    // Scan farthest-first so the lane closest to ptr overrides.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = ptr + LANE_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/demux_lane_asm.sv
// demux_lane_asm: per-lane LSB-first word assembly, holding register and sticky overflow.
// DEMUX_COLLECT_PARITY_EN adds a parity input checked on word completion and a sticky error.
module demux_lane_asm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take_i,
  input  logic             bit_i,
  input  logic             drain_i,
  input  logic             ovf_clr_i,
`ifdef DEMUX_COLLECT_PARITY_EN
  input  logic             par_i,
  output logic             perr_o,
`endif
  output logic [WIDTH-1:0] hold_o,
  output logic             full_o,
  output logic             ovf_o
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d, word;
  logic full_q, full_d, ovf_q, ovf_d, last, accept;
  always_comb begin
    last = take_i && cnt_q == CW'(WIDTH - 1);
    word = {bit_i, sh_q[WIDTH-2:0]};
    // A draining lane can take the new word in the same cycle without losing it.
    accept = last && (!full_q || drain_i);
    sh_d = take_i ? (sh_q & ~(WIDTH'(1) << cnt_q)) | (WIDTH'(bit_i) << cnt_q) : sh_q;
    cnt_d = take_i ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    hold_d = accept ? word : hold_q;
    full_d = accept | (full_q & ~drain_i);
    ovf_d = (last & full_q & ~drain_i) | (ovf_q & ~ovf_clr_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      hold_q <= hold_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef DEMUX_COLLECT_PARITY_EN
  logic perr_q, perr_d;
  assign perr_d = (last & ((^word) != par_i)) | (perr_q & ~ovf_clr_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else perr_q <= perr_d;
  end
  assign perr_o = perr_q;
`endif
  assign hold_o = hold_q;
  assign full_o = full_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/demux_lane_collector.sv
// demux_lane_collector: four lane assemblers feeding one valid/ready port via a round-robin arbiter.
// DEMUX_COLLECT_PARITY_EN adds y_par, out_par and sticky per-lane perr.
module demux_lane_collector
  import demux_collect_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_vld,
  input  logic [LANE_W-1:0]    s,
  input  logic [NUM_LANES-1:0] y,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANE_W-1:0]    out_lane,
  output logic [WIDTH-1:0]     out_data,
  output logic [NUM_LANES-1:0] ovf,
  input  logic                 ovf_clr
`ifdef DEMUX_COLLECT_PARITY_EN
  ,
  input  logic                 y_par,
  output logic                 out_par,
  output logic [NUM_LANES-1:0] perr
`endif
);
  arb_state_e state_q, state_d;
  logic [LANE_W-1:0] ptr_q, ptr_d, lane_q, lane_d;
  logic [NUM_LANES-1:0] full;
  logic [WIDTH-1:0] hold [NUM_LANES];
  logic hs, arb;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    demux_lane_asm #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .take_i   (bit_vld && s == LANE_W'(l)),
      .bit_i    (y[l]),
      .drain_i  (hs && lane_q == LANE_W'(l)),
      .ovf_clr_i(ovf_clr),
`ifdef DEMUX_COLLECT_PARITY_EN
      .par_i    (y_par),
      .perr_o   (perr[l]),
`endif
      .hold_o   (hold[l]),
      .full_o   (full[l]),
      .ovf_o    (ovf[l])
    );
  end
  always_comb begin
    hs = state_q == ARB_PRESENT && out_rdy;
    arb = state_q == ARB_IDLE && |full;
    state_d = hs ? ARB_IDLE : arb ? ARB_PRESENT : state_q;
    lane_d = arb ? rr_pick(full, ptr_q) : lane_q;
    ptr_d = hs ? lane_q + LANE_W'(1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      lane_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lane_q <= lane_d;
    end
  end
  // The presented lane's hold register cannot change until it is drained, so a mux suffices.
  assign out_vld = state_q == ARB_PRESENT;
  assign out_lane = lane_q;
  assign out_data = hold[lane_q];
`ifdef DEMUX_COLLECT_PARITY_EN
  assign out_par = ^out_data;
`endif
endmodule

// File: tb/tb_demux_lane_collector.sv
// tb_demux_lane_collector: directed and randomized checks against a per-lane word queue model.
// Parity checks are included when DEMUX_COLLECT_PARITY_EN is defined.
module tb_demux_lane_collector;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, bit_vld, out_rdy, ovf_clr, out_vld;
  logic [1:0] s, out_lane;
  logic [3:0] y, ovf;
  logic [W-1:0] out_data;
`ifdef DEMUX_COLLECT_PARITY_EN
  logic y_par, out_par;
  logic [3:0] perr;
`endif
  int checks = 0, failures = 0, pushed = 0;
  logic [W-1:0] exp_q[4][$];
  int lane_order[$];
  logic [W-1:0] acc[4];
  int nb[4];
  logic [W-1:0] wa, wb;
  logic [W-1:0] w4[4];

  demux_lane_collector #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bit_vld(bit_vld), .s(s), .y(y),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_lane(out_lane), .out_data(out_data),
    .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef DEMUX_COLLECT_PARITY_EN
    , .y_par(y_par), .out_par(out_par), .perr(perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      exp_q[l].delete();
      nb[l] = 0;
      acc[l] = '0;
    end
  endtask

  // One clock: drive at the negedge, check any handshake, update the model, end at the next negedge.
  task automatic tick(input logic v, input logic [1:0] sel, input logic b, input logic rdy, input logic clr = 1'b0);
    bit_vld = v;
    s = sel;
    y = 4'($urandom);
    y[sel] = b;
    out_rdy = rdy;
    ovf_clr = clr;
    #1;
    if (out_vld && rdy) begin
      chk("hs_pending", 32'(exp_q[out_lane].size() > 0), 32'd1);
      if (exp_q[out_lane].size() > 0) chk("hs_data", 32'(out_data), 32'(exp_q[out_lane].pop_front()));
      lane_order.push_back(int'(out_lane));
    end
    if (v) begin
      acc[sel][nb[sel]] = b;
      nb[sel]++;
      if (nb[sel] == W) begin
        exp_q[sel].push_back(acc[sel]);
        nb[sel] = 0;
        pushed++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] lane, input logic [W-1:0] word, input logic rdy);
    for (int i = 0; i < W; i++) tick(1'b1, lane, word[i], rdy);
  endtask

  initial begin
    rst = 1'b1; bit_vld = 1'b0; s = '0; y = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
`ifdef DEMUX_COLLECT_PARITY_EN
    y_par = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_lane", 32'(out_lane), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    // Single word on lane 2, one arbitration cycle of latency
    send(2'd2, 8'h8D, 1'b1);
    chk("t1_vld_early", 32'(out_vld), 0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t1_vld", 32'(out_vld), 1);
    chk("t1_lane", 32'(out_lane), 2);
    chk("t1_data", 32'(out_data), 32'h8D);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t1_vld_after", 32'(out_vld), 0);
    // Round-robin interleave across all lanes
    lane_order.delete();
    for (int l = 0; l < 4; l++) w4[l] = W'($urandom);
    for (int k = 0; k < 32; k++) tick(1'b1, 2'(k % 4), w4[k % 4][k / 4], 1'b1);
    repeat (8) tick(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t2_count", 32'(lane_order.size()), 4);
    for (int i = 0; i < 4 && i < lane_order.size(); i++) chk("t2_order", 32'(lane_order[i]), 32'(i));
    chk("t2_ovf", 32'(ovf), 0);
    // Two words on lane 1 with consumer stalled: second is dropped
    wa = W'($urandom);
    wb = W'($urandom);
    send(2'd1, wa, 1'b0);
    send(2'd1, wb, 1'b0);
    void'(exp_q[1].pop_back());
    chk("t3_ovf", 32'(ovf), 32'b0010);
    chk("t3_vld", 32'(out_vld), 1);
    chk("t3_lane", 32'(out_lane), 1);
    chk("t3_data", 32'(out_data), 32'(wa));
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(ovf), 0);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t3_vld_after", 32'(out_vld), 0);
    // Lane 3 completes a word on the same edge its previous word drains
    wa = W'($urandom);
    wb = W'($urandom);
    send(2'd3, wa, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_vld", 32'(out_vld), 1);
    for (int i = 0; i < W - 1; i++) tick(1'b1, 2'd3, wb[i], 1'b0);
    tick(1'b1, 2'd3, wb[W-1], 1'b1);
    chk("t4_ovf", 32'(ovf), 0);
    chk("t4_idle", 32'(out_vld), 0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_vld2", 32'(out_vld), 1);
    chk("t4_lane2", 32'(out_lane), 3);
    chk("t4_data2", 32'(out_data), 32'(wb));
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    // Reset in the middle of a word on lane 0
    wa = W'($urandom);
    wb = W'($urandom);
    for (int i = 0; i < 5; i++) tick(1'b1, 2'd0, wa[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_vld", 32'(out_vld), 0);
    chk("t5_lane", 32'(out_lane), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_ovf", 32'(ovf), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(2'd0, wb, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_vld2", 32'(out_vld), 1);
    chk("t5_lane2", 32'(out_lane), 0);
    chk("t5_data2", 32'(out_data), 32'(wb));
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    // Random traffic with an always-ready consumer: nothing may be lost
    lane_order.delete();
    pushed = 0;
    repeat (600) tick($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    repeat (12) tick(1'b0, 2'd0, 1'b0, 1'b1);
    for (int l = 0; l < 4; l++) chk("rnd_leftover", 32'(exp_q[l].size()), 0);
    chk("rnd_words", 32'(lane_order.size()), 32'(pushed));
    chk("rnd_ovf", 32'(ovf), 0);
`ifdef DEMUX_COLLECT_PARITY_EN
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("par_clr", 32'(perr), 0);
    y_par = 1'b0;
    send(2'd2, 8'h8D, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("par_out", 32'(out_par), 0);
    chk("par_ok", 32'(perr), 0);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    y_par = 1'b1;
    send(2'd2, 8'h8D, 1'b1);
    y_par = 1'b0;
    chk("par_err", 32'(perr), 32'b0100);
    repeat (4) tick(1'b0, 2'd0, 1'b0, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
